address_seq16: RTL
==================

# address_seq16

Address sequencer that sits directly downstream of the `address_op16` AXI4-Lite register block. It latches the base, stride and group-count configuration from that block's registers on a start pulse. It then emits addresses in groups of 16 lanes on a valid/ready stream to the spin-memory fetch stage. Busy, done and progress status are returned to the register block's read-back path.

## Interface
Parameters:
- `ADDR_W`, 32, address and stride width.
- `CNT_W`, 16, group-count and progress-counter width.
- `GROUP`, 16, lanes per group; fixed at 16 by this design, so the lane index is 4 bits.

Ports:
- `ACLK`  in  1  sole clock; all logic rising-edge.
- `ARESET`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse from control register write.
- `abort`  in  1  single-cycle pulse; cancels a run.
- `cfg_base`  in  ADDR_W  first address.
- `cfg_stride`  in  ADDR_W  address increment per beat.
- `cfg_count`  in  CNT_W  number of 16-lane groups.
- `m_valid`  out  1  address beat valid.
- `m_ready`  in  1  downstream accepts beat.
- `m_addr`  out  ADDR_W  beat address.
- `m_lane`  out  4  lane index within group, 0..15.
- `m_last_grp`  out  1  beat is lane 15.
- `m_last`  out  1  final beat of run.
- `busy`  out  1  run in progress.
- `done`  out  1  run completed normally; held until next start.
- `groups_done`  out  CNT_W  groups fully handed off in current/last run.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + `start`, `cfg_count`≠0:
  - latch cfg into internal registers; later cfg changes are ignored for the rest of the run.
  - addr←`cfg_base`, lane←0, groups_done←0.
  - go to RUN.
- IDLE/DONE + `start`, `cfg_count`=0: groups_done←0, go to DONE; no beats are emitted.
- RUN: `m_valid`=1. A handshake (`m_valid`&`m_ready`) advances the beat:
  - lane←lane+1, modulo 16.
  - addr←addr+stride, modulo 2^ADDR_W; wrap is silent.
  - If lane was 15: groups_done←groups_done+1.
  - If lane was 15 and groups_done+1 = latched count: go to DONE.
- `m_last` = (lane==15) & (groups_done == count−1). `m_last_grp` = (lane==15).
- Beat k (0-based) carries addr = base + k·stride mod 2^ADDR_W. Total beats = 16·count.
- `start` during RUN is ignored.
- `abort` in RUN goes to IDLE; `done` stays 0 and `groups_done` keeps its value.
- Simultaneous `abort` and final handshake: abort wins, state goes to IDLE; the beat is still counted as accepted by downstream.
- `abort` in IDLE/DONE has no effect. `start`+`abort` in the same cycle: abort wins, no run starts.
- `busy` = (state==RUN). `done` = (state==DONE).

## Timing
- Reset values: state IDLE; `m_valid`, `m_last`, `m_last_grp`, `busy`, `done` = 0; `m_addr`, `m_lane`, `groups_done` = 0.
- `ARESET` mid-run clears everything immediately, asynchronously. No beat is considered issued after reset.
- `start` sampled at edge N gives `m_valid`=1 and `m_addr`=base after edge N, i.e. 1-cycle latency.
- Handshake rules:
  - Once `m_valid` is high, `m_addr`, `m_lane`, `m_last_grp` and `m_last` hold stable until the handshake.
  - `m_valid` does not drop without a handshake, except on abort or reset.
- Throughput is 1 beat/cycle with `m_ready` held high.
- The final handshake at edge M gives `m_valid`=0, `done`=1 and `busy`=0 after edge M.
- All outputs are registered; there is no combinational path from `m_ready` to any output.

## Structure
- Package `address_seq16_pkg`:
  - `seq_state_t` enum (IDLE, RUN, DONE).
  - `GROUP_LANES` = 16.
  - `LANE_W` = 4.
- Single module, no sub-modules. Lane counter, address accumulator and group counter are flat registers.

## Test plan
- base=0x1000, stride=4, count=1, ready always 1 → 16 beats 0x1000..0x103C on consecutive cycles; `m_last` only on 0x103C; `done`=1 next cycle; `groups_done`=1.
- count=2, stride=8, ready toggled every other cycle → 32 beats; payload stable while stalled; `m_last_grp` at beats 15 and 31; `groups_done` steps 1 then 2.
- base=0xFFFF_FFF0, stride=0x10, count=1 → second beat address 0x0000_0000 (wrap); run completes normally.
- count=0 start → no `m_valid`; `done`=1 one cycle after start; `groups_done`=0.
- count=3, abort after beat 20 → `m_valid` drops next cycle; state IDLE; `done`=0; `groups_done`=1; a second `start` then restarts from base.
- Assert `ARESET` mid-group → all outputs 0 immediately; `start` and cfg changes during RUN are ignored (addresses follow the originally latched stride).

Source files
------------

// File: rtl/address_seq16_pkg.sv
// rtl/address_seq16_pkg.sv - shared types and constants for the address sequencer
package address_seq16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int GROUP_LANES = 16;
    localparam int LANE_W      = 4;

endpackage

// File: rtl/address_seq16.sv
// rtl/address_seq16.sv - emits base + k*stride addresses in 16-lane groups on a valid/ready stream
module address_seq16
    import address_seq16_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    parameter int GROUP  = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_lane,
    output logic              m_last_grp,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  groups_done
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(GROUP - 1);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  groups_q;
    logic [LANE_W-1:0] lane_q;

    logic handshake;
    logic lane_last;
    logic group_last;
    logic launch;

    assign handshake  = (state == RUN) && m_ready;
    assign lane_last  = (lane_q == LAST_LANE);
    assign group_last = (groups_q == (count_q - CNT_W'(1)));
    // abort beats a coincident start, so a launch needs a clean start pulse
    assign launch     = (state != RUN) && start && !abort;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (launch) begin
                    state_nxt = (cfg_count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (handshake && lane_last && group_last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // an aborted final beat still advances the counters: downstream took it
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            groups_q <= '0;
            lane_q   <= '0;
        end else if (launch) begin
            groups_q <= '0;
            if (cfg_count != '0) begin
                addr_q   <= cfg_base;
                stride_q <= cfg_stride;
                count_q  <= cfg_count;
                lane_q   <= '0;
            end
        end else if (handshake) begin
            addr_q <= addr_q + stride_q;
            lane_q <= lane_q + LANE_W'(1);
            if (lane_last) begin
                groups_q <= groups_q + CNT_W'(1);
            end
        end
    end

    assign m_valid     = (state == RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign m_addr      = addr_q;
    assign m_lane      = lane_q;
    assign m_last_grp  = (state == RUN) && lane_last;
    assign m_last      = (state == RUN) && lane_last && group_last;
    assign groups_done = groups_q;

endmodule
